// File: rtl/stp_wrapper.sv
// -----------------------------------------------------------------------------
// stp_wrapper
//   Serial-to-parallel converter for the FFT datapath.
//   It collects NWORDS samples of WIDTH bits, one on each strobe, and presents
//   them together on a flat parallel bus. The oldest sample is at index 0 and
//   the newest sample is at index NWORDS-1.
//
// Ports
//   clk            : system clock; all logic updates on the rising edge
//   n_rst          : synchronous reset, active HIGH despite its name
//   it_cnt_strobe  : shift enable; one word is accepted on each cycle it is high
//   serial_in      : sample word; ignored while it_cnt_strobe is low
//   data_par_in    : registered parallel frame, [NWORDS-1:0][WIDTH-1:0]
//   par_valid      : registered 1-cycle pulse; a full frame has just completed
// -----------------------------------------------------------------------------
module stp_wrapper #(
  parameter int WIDTH  = 16,
  parameter int NWORDS = 48
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           it_cnt_strobe,
  input  logic [WIDTH-1:0]               serial_in,
  output logic [NWORDS-1:0][WIDTH-1:0]   data_par_in,
  output logic                           par_valid
);

  // The counter width is kept at 1 or more so that a degenerate NWORDS=1
  // build still elaborates.
  localparam int            CW       = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NWORDS - 1);

  logic [NWORDS-1:0][WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]                cnt_q,  cnt_d;
  logic                         valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    if (it_cnt_strobe) begin
      // The new word enters at the top and every other word moves down by one.
      // The word in index 0 falls off the end. When the strobe is low,
      // serial_in is never selected, so an X on that input cannot get into
      // the register.
      if (NWORDS > 1) begin
        data_d = {serial_in, data_q[NWORDS-1:1]};
      end else begin
        data_d[0] = serial_in;
      end
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        valid_d = 1'b1;
      end else begin
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign data_par_in = data_q;
  assign par_valid   = valid_q;

endmodule

// File: tb/tb_stp_wrapper.sv
// -----------------------------------------------------------------------------
// tb_stp_wrapper
//   Self-checking bench for stp_wrapper.
//   The reference model is a FIFO window of the last NWORDS accepted words.
//   The model raises par_valid whenever the number of words accepted since the
//   last reset is a positive multiple of NWORDS.
// -----------------------------------------------------------------------------
module tb_stp_wrapper;
  localparam int W = 16;
  localparam int N = 48;

  logic                   clk = 1'b0;
  logic                   n_rst;
  logic                   it_cnt_strobe;
  logic [W-1:0]           serial_in;
  logic [N-1:0][W-1:0]    data_par_in;
  logic                   par_valid;

  int tests  = 0;
  int failed = 0;
  int pulses = 0;

  logic [W-1:0]        win[$];
  int                  accepted;
  logic                exp_valid;
  logic [N-1:0][W-1:0] exp_bus;

  stp_wrapper #(.WIDTH(W), .NWORDS(N)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .it_cnt_strobe (it_cnt_strobe),
    .serial_in     (serial_in),
    .data_par_in   (data_par_in),
    .par_valid     (par_valid)
  );

  always #5 clk = ~clk;

  task automatic chk_bus(input string tag, input logic [N-1:0][W-1:0] obs,
                         input logic [N-1:0][W-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    win.delete();
    for (int i = 0; i < N; i++) win.push_back('0);
    accepted  = 0;
    exp_valid = 1'b0;
  endtask

  // Runs one clock cycle and then compares the DUT with the model.
  task automatic step(input logic rst, input logic stb, input logic [W-1:0] d);
    n_rst         = rst;
    it_cnt_strobe = stb;
    serial_in     = d;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else if (stb) begin
      win.push_back(d);
      void'(win.pop_front());
      accepted++;
      exp_valid = ((accepted % N) == 0);
    end else begin
      exp_valid = 1'b0;
    end
    for (int i = 0; i < N; i++) exp_bus[i] = win[i];
    chk_bus("bus", data_par_in, exp_bus);
    chk_int("par_valid", int'(par_valid), int'(exp_valid));
    if (par_valid === 1'b1) pulses++;
  endtask

  logic [N-1:0][W-1:0] ref_bus;

  initial begin
    n_rst = 1'b1; it_cnt_strobe = 1'b1; serial_in = '0;
    model_reset();

    // 1: reset held for 2 clocks with the strobe high
    step(1'b1, 1'b1, W'($urandom));
    step(1'b1, 1'b1, W'($urandom));
    chk_bus("reset_zero", data_par_in, '0);
    chk_int("reset_valid", int'(par_valid), 0);

    // 2: load 0..47, then idle with X on serial_in
    pulses = 0;
    for (int k = 0; k < N; k++) step(1'b0, 1'b1, W'(k));
    for (int k = 0; k < 50; k++) step(1'b0, 1'b0, 'x);
    for (int i = 0; i < N; i++) ref_bus[i] = W'(i);
    chk_bus("load_ramp", data_par_in, ref_bus);
    chk_int("load_pulses", pulses, 1);

    // 3: reload without reset, (47-k)%17
    pulses = 0;
    for (int k = 0; k < N; k++) step(1'b0, 1'b1, W'((47 - k) % 17));
    step(1'b0, 1'b0, 'x);
    chk_int("reload_w0", int'(data_par_in[0]), 13);
    chk_int("reload_w47", int'(data_par_in[N-1]), 0);
    for (int i = 0; i < N; i++) ref_bus[i] = W'((47 - i) % 17);
    chk_bus("reload", data_par_in, ref_bus);
    chk_int("reload_pulses", pulses, 1);

    // 4: gapped load of 0..47
    pulses = 0;
    for (int k = 0; k < N; k++) begin
      step(1'b0, 1'b1, W'(k));
      repeat ($urandom_range(1, 5)) step(1'b0, 1'b0, W'($urandom));
    end
    for (int i = 0; i < N; i++) ref_bus[i] = W'(i);
    chk_bus("gapped", data_par_in, ref_bus);
    chk_int("gapped_pulses", pulses, 1);

    // 5: reset in mid-frame, then 48 words 0x100+k
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1, W'($urandom));
    step(1'b1, 1'b0, '0);
    pulses = 0;
    for (int k = 0; k < N - 1; k++) step(1'b0, 1'b1, W'(16'h100 + k));
    chk_int("midrst_early", pulses, 0);
    step(1'b0, 1'b1, W'(16'h100 + N - 1));
    chk_int("midrst_pulse", int'(par_valid), 1);
    for (int i = 0; i < N; i++) ref_bus[i] = W'(16'h100 + i);
    chk_bus("midrst", data_par_in, ref_bus);

    // 6: overflow with 50 words; the counter should be at 2 afterwards
    step(1'b1, 1'b0, '0);
    pulses = 0;
    for (int k = 0; k < 50; k++) step(1'b0, 1'b1, W'(k));
    for (int i = 0; i < N; i++) ref_bus[i] = W'(i + 2);
    chk_bus("overflow", data_par_in, ref_bus);
    chk_int("overflow_pulses", pulses, 1);
    pulses = 0;
    for (int k = 0; k < N - 3; k++) step(1'b0, 1'b1, W'($urandom));
    chk_int("cnt2_no_pulse", pulses, 0);
    step(1'b0, 1'b1, W'($urandom));
    chk_int("cnt2_pulse", int'(par_valid), 1);

    // Random traffic compared against the model
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), W'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
